au_cnt_c: RTL and testbench
===========================

// Module: au_cnt_c
// PURPOSE
//   Registered up-counter that closes the loop around AU_inc_c. The counter
//   register drives AU_inc_c.a, the increment enable drives AU_inc_c.ci, and
//   z/co are captured on the next clock edge.
//   Adds synchronous load, optional saturation, terminal-count decode and a
//   sticky overflow flag. It is the state-holding stage downstream of the
//   incrementer, used for address/sequence generators in the arith-unit library.
// PARAMETERS
//   WIDTH  8  counter word length (>= 1)
//   ARCH   0  AU_inc_c prefix architecture passed through (0 to 2)
//   SAT    0  0 = wrap modulo 2**WIDTH; 1 = saturate at all-ones
// PORTS
//   clk      in   1      clock; all state updates on rising edge
//   rst      in   1      synchronous reset, active-high
//   ld       in   1      load strobe: cnt <= ld_val
//   ld_val   in   WIDTH  load value
//   inc      in   1      increment enable (drives AU_inc_c.ci)
//   ovf_clr  in   1      clear sticky overflow flag
//   cnt      out  WIDTH  current count (registered)
//   tc       out  1      terminal count: cnt == all-ones (combinational from cnt)
//   co       out  1      registered carry event, one-cycle pulse
//   ovf      out  1      sticky overflow flag (registered)
// BEHAVIOUR
//   - Reset: one clk edge with rst=1 gives cnt=0, co=0, ovf=0, so tc=0
//     (tc=1 only when WIDTH maxes at 0, which is impossible).
//     rst overrides all other inputs.
//   - Priority per edge: rst > ld > inc > hold.
//   - ld=1: cnt <= ld_val and co <= 0, regardless of inc. ovf is unaffected
//     except by ovf_clr.
//   - ld=0, inc=1, SAT=0: {co, cnt} <= {1'b0, cnt} + 1, taken from AU_inc_c z/co.
//     At all-ones, cnt wraps to 0 and co=1 for exactly one cycle.
//   - ld=0, inc=1, SAT=1, tc=1: cnt holds at all-ones and co <= 1 (blocked
//     carry). co stays 1 on every edge where inc remains high at max.
//   - ld=0, inc=0: cnt holds and co <= 0.
//   - Latency: 1 clk from inc/ld to updated cnt. tc follows cnt in the same
//     cycle. co is aligned with the cnt value produced by the carrying increment.
//   - ovf: set on any edge where the next co = 1. Cleared by ovf_clr=1 when no
//     set occurs on that edge. Simultaneous set and ovf_clr: set wins, ovf=1.
//   - Arithmetic is unsigned modulo 2**WIDTH; no signed interpretation.
//   - WIDTH=1: the counter toggles 0->1->0 with co on the 1->0 edge (SAT=0),
//     or sticks at 1 (SAT=1).
//   - rst asserted mid-count: the next edge forces reset values and discards a
//     pending co/ovf set.
//   - Parameter check at elaboration: WIDTH<1, ARCH outside 0..2, or SAT outside
//     0..1 prints an ERROR and calls $finish.
// TESTING (WIDTH=8 unless stated; sweep ARCH 0..2)
//   1. rst=1 for 1 edge after random state -> cnt=0x00, co=0, ovf=0, tc=0.
//   2. SAT=0: ld_val=0xFD, then inc=1 for 4 edges -> cnt 0xFE,0xFF,0x00,0x01;
//      tc=1 only at 0xFF; co=1 only with cnt=0x00; ovf=1 afterwards.
//   3. SAT=1: ld_val=0xFE, inc=1 for 3 edges -> cnt 0xFF,0xFF,0xFF;
//      co=0,1,1; ovf=1.
//   4. ld=1, ld_val=0x10, inc=1 on the same edge -> cnt=0x10, co=0
//      (ld wins over inc).
//   5. ovf=1, then ovf_clr=1 on the edge where a wrap occurs -> ovf stays 1;
//      ovf_clr=1 on the next quiet edge -> ovf=0.
//   6. Random ld/inc/rst for 10k cycles against a behavioural model
//      ({co, cnt} = cnt + inc with the same priority); also run WIDTH=1 and
//      WIDTH=33.

Source files
------------

// File: rtl/au_cnt_c.sv
// ---------------------------------------------------------------------------
// au_inc_c : WIDTH-bit incrementer, z = a + ci, co = carry out of the MSB.
//   a   in  WIDTH  operand
//   ci  in  1      carry in (increment enable)
//   z   out WIDTH  sum modulo 2**WIDTH
//   co  out 1      carry out
// The carry into bit i is ci AND a[0..i-1]. That is a prefix-AND over the
// vector {a, ci}, built in one of three styles:
//   ARCH 0 ripple, ARCH 1 Sklansky, ARCH 2 Kogge-Stone.
//
// au_cnt_c : registered up-counter built around au_inc_c.
//   clk      in  1      clock, rising edge
//   rst      in  1      synchronous reset, active-high (highest priority)
//   ld       in  1      load strobe, cnt <= ld_val (beats inc)
//   ld_val   in  WIDTH  load value
//   inc      in  1      increment enable
//   ovf_clr  in  1      clear sticky overflow (a new set on the same edge wins)
//   cnt      out WIDTH  registered count
//   tc       out 1      terminal count, cnt == all-ones (combinational)
//   co       out 1      registered carry pulse, aligned with the wrapped count
//   ovf      out 1      sticky overflow flag
// SAT=1 holds the count at all-ones. A blocked increment still raises co.
// ---------------------------------------------------------------------------

module au_inc_c #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic             ci,
  output logic [WIDTH-1:0] z,
  output logic             co
);

  localparam int N = WIDTH + 1;
  localparam int L = $clog2(N);

  logic [N-1:0]      x;
  logic [N-1:0]      pfx;
  logic [L:0][N-1:0] lvl;

  // x[0] = ci, x[i+1] = a[i]; pfx[i] = AND of x[0..i] = carry into bit i
  assign x = {a, ci};

  always_comb begin
    lvl    = '0;
    pfx    = '0;
    lvl[0] = x;
    if (ARCH == 0) begin
      pfx[0] = x[0];
      for (int i = 1; i < N; i++) begin
        pfx[i] = pfx[i-1] & x[i];
      end
    end else begin
      for (int k = 0; k < L; k++) begin
        lvl[k+1] = lvl[k];
        if (ARCH == 2) begin
          // Kogge-Stone: every node combines with the node 2**k below it
          for (int i = (1 << k); i < N; i++) begin
            lvl[k+1][i] = lvl[k][i] & lvl[k][i-(1 << k)];
          end
        end else begin
          // Sklansky: the upper half of each 2**(k+1) block takes the
          // last node of its lower half
          for (int b = 0; b < N; b += (2 << k)) begin
            for (int j = (1 << k); j < (2 << k); j++) begin
              if (b + j < N) begin
                lvl[k+1][b+j] = lvl[k][b+j] & lvl[k][b+(1 << k)-1];
              end
            end
          end
        end
      end
      pfx = lvl[L];
    end
  end

  assign z  = x[N-1:1] ^ pfx[N-2:0];
  assign co = pfx[N-1];

endmodule

module au_cnt_c #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             inc,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             co,
  output logic             ovf
);

  if (WIDTH < 1 || ARCH < 0 || ARCH > 2 || SAT < 0 || SAT > 1) begin : g_param_err
    $fatal(1, "ERROR: au_cnt_c illegal parameters WIDTH=%0d ARCH=%0d SAT=%0d",
           WIDTH, ARCH, SAT);
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] inc_z;
  logic             inc_co;

  au_inc_c #(
    .WIDTH (WIDTH),
    .ARCH  (ARCH)
  ) u_inc (
    .a  (cnt_q),
    .ci (inc),
    .z  (inc_z),
    .co (inc_co)
  );

  assign tc = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    co_d  = 1'b0;
    if (ld) begin
      cnt_d = ld_val;
    end else if (inc) begin
      if (SAT == 1 && tc) begin
        // saturated: count stays at all-ones, the lost carry is reported
        co_d = 1'b1;
      end else begin
        cnt_d = inc_z;
        co_d  = inc_co;
      end
    end
    // a carry on this edge outranks a clear request
    ovf_d = co_d | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      co_q  <= co_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign co  = co_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_au_cnt_c.sv
module tb_au_cnt_c;

  localparam int NI = 8;
  localparam int W_T [NI] = '{8, 8, 8, 8, 1, 1, 33, 33};
  localparam int A_T [NI] = '{0, 1, 2, 1, 0, 2, 2, 0};
  localparam int S_T [NI] = '{0, 0, 0, 1, 0, 1, 0, 1};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ld;
  logic        inc;
  logic        ovf_clr;
  logic [32:0] ld_val;

  logic [32:0] cnt_a [NI];
  logic        co_a  [NI];
  logic        ovf_a [NI];
  logic        tc_a  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = W_T[g];
    logic [W-1:0] c_w;
    logic         co_w, ovf_w, tc_w;
    au_cnt_c #(
      .WIDTH (W),
      .ARCH  (A_T[g]),
      .SAT   (S_T[g])
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .ld      (ld),
      .ld_val  (ld_val[W-1:0]),
      .inc     (inc),
      .ovf_clr (ovf_clr),
      .cnt     (c_w),
      .tc      (tc_w),
      .co      (co_w),
      .ovf     (ovf_w)
    );
    assign cnt_a[g] = 33'(c_w);
    assign co_a[g]  = co_w;
    assign ovf_a[g] = ovf_w;
    assign tc_a[g]  = tc_w;
  end

  int checks   = 0;
  int failures = 0;

  // behavioural reference: plain integer arithmetic per instance
  longint unsigned m_cnt [NI];
  bit              m_co  [NI];
  bit              m_ovf [NI];

  task automatic model_step();
    for (int g = 0; g < NI; g++) begin
      longint unsigned mx;
      longint unsigned s;
      bit              nco;
      mx  = (64'd1 << W_T[g]) - 64'd1;
      nco = 1'b0;
      if (rst) begin
        m_cnt[g] = 0;
        m_co[g]  = 1'b0;
        m_ovf[g] = 1'b0;
      end else begin
        if (ld) begin
          m_cnt[g] = 64'(ld_val) & mx;
        end else if (inc) begin
          if (S_T[g] == 1 && m_cnt[g] == mx) begin
            nco = 1'b1;
          end else begin
            s        = m_cnt[g] + 1;
            nco      = (s > mx);
            m_cnt[g] = s & mx;
          end
        end
        m_co[g]  = nco;
        m_ovf[g] = nco ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf[g]);
      end
    end
  endtask

  // driver tasks
  task automatic set_in(input logic r, input logic l, input logic [32:0] v,
                        input logic i, input logic oc);
    rst     = r;
    ld      = l;
    ld_val  = v;
    inc     = i;
    ovf_clr = oc;
  endtask

  function automatic logic [32:0] rnd33();
    logic [63:0] r64;
    r64 = {$urandom(), $urandom()};
    return r64[32:0];
  endfunction

  // inputs change on negedge; state checked on the following negedge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int n = 0; n < 20; n++) begin
      set_in(1'b0, $urandom_range(0, 3) == 0, rnd33(), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3) == 0);
      tick();
    end
    set_in(1'b1, 1'b1, 33'h1_FFFF_FFFF, 1'b1, 1'b0);
    tick();
    for (int g = 0; g < NI; g++) begin
      checks++;
      if (cnt_a[g] !== 33'd0 || co_a[g] !== 1'b0 || ovf_a[g] !== 1'b0 || tc_a[g] !== 1'b0) begin
        failures++;
        $display("FAIL reset inst%0d cnt=%0h co=%b ovf=%b tc=%b expected 0/0/0/0",
                 g, cnt_a[g], co_a[g], ovf_a[g], tc_a[g]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_c [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    set_in(1'b1, 1'b0, 33'd0, 1'b0, 1'b0); tick();
    set_in(1'b0, 1'b1, 33'hFD, 1'b0, 1'b0); tick();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b0, 33'd0, 1'b1, 1'b0);
      tick();
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (cnt_a[g] !== {25'd0, exp_c[i]} || tc_a[g] !== (i == 1) || co_a[g] !== (i == 2)) begin
          failures++;
          $display("FAIL wrap step%0d inst%0d cnt=%0h tc=%b co=%b expected %0h/%b/%b",
                   i, g, cnt_a[g], tc_a[g], co_a[g], exp_c[i], i == 1, i == 2);
        end
      end
    end
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (ovf_a[g] !== 1'b1) begin
        failures++;
        $display("FAIL wrap_ovf inst%0d ovf=%b expected 1", g, ovf_a[g]);
      end
    end
  endtask

  task automatic test_sat();
    bit exp_co [3] = '{1'b0, 1'b1, 1'b1};
    set_in(1'b1, 1'b0, 33'd0, 1'b0, 1'b0); tick();
    set_in(1'b0, 1'b1, 33'hFE, 1'b0, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b0, 33'd0, 1'b1, 1'b0);
      tick();
      checks++;
      if (cnt_a[3] !== 33'hFF || co_a[3] !== exp_co[i] || tc_a[3] !== 1'b1) begin
        failures++;
        $display("FAIL sat step%0d cnt=%0h co=%b tc=%b expected ff/%b/1",
                 i, cnt_a[3], co_a[3], tc_a[3], exp_co[i]);
      end
    end
    checks++;
    if (ovf_a[3] !== 1'b1) begin
      failures++;
      $display("FAIL sat_ovf ovf=%b expected 1", ovf_a[3]);
    end
  endtask

  task automatic test_ld_priority();
    set_in(1'b1, 1'b0, 33'd0, 1'b0, 1'b0); tick();
    set_in(1'b0, 1'b1, 33'hFF, 1'b0, 1'b0); tick();
    set_in(1'b0, 1'b0, 33'd0, 1'b1, 1'b0); tick();
    set_in(1'b0, 1'b1, 33'h10, 1'b1, 1'b0); tick();
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (cnt_a[g] !== 33'h10 || co_a[g] !== 1'b0 || ovf_a[g] !== 1'b1) begin
        failures++;
        $display("FAIL ld_priority inst%0d cnt=%0h co=%b ovf=%b expected 10/0/1",
                 g, cnt_a[g], co_a[g], ovf_a[g]);
      end
    end
  endtask

  task automatic test_ovf_clr();
    set_in(1'b1, 1'b0, 33'd0, 1'b0, 1'b0); tick();
    set_in(1'b0, 1'b1, 33'hFF, 1'b0, 1'b0); tick();
    set_in(1'b0, 1'b0, 33'd0, 1'b1, 1'b0); tick();
    set_in(1'b0, 1'b1, 33'hFF, 1'b0, 1'b0); tick();
    set_in(1'b0, 1'b0, 33'd0, 1'b1, 1'b1); tick();
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (cnt_a[g] !== 33'h0 || co_a[g] !== 1'b1 || ovf_a[g] !== 1'b1) begin
        failures++;
        $display("FAIL ovf_set_wins inst%0d cnt=%0h co=%b ovf=%b expected 0/1/1",
                 g, cnt_a[g], co_a[g], ovf_a[g]);
      end
    end
    set_in(1'b0, 1'b0, 33'd0, 1'b0, 1'b1); tick();
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (ovf_a[g] !== 1'b0 || co_a[g] !== 1'b0) begin
        failures++;
        $display("FAIL ovf_clear inst%0d ovf=%b co=%b expected 0/0", g, ovf_a[g], co_a[g]);
      end
    end
  endtask

  task automatic test_width1();
    bit e4c [3] = '{1'b1, 1'b0, 1'b1};
    bit e4o [3] = '{1'b0, 1'b1, 1'b0};
    bit e5o [3] = '{1'b0, 1'b1, 1'b1};
    set_in(1'b1, 1'b0, 33'd0, 1'b0, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b0, 33'd0, 1'b1, 1'b0);
      tick();
      checks++;
      if (cnt_a[4] !== 33'(e4c[i]) || co_a[4] !== e4o[i]) begin
        failures++;
        $display("FAIL w1_wrap step%0d cnt=%0h co=%b expected %0h/%b",
                 i, cnt_a[4], co_a[4], e4c[i], e4o[i]);
      end
      checks++;
      if (cnt_a[5] !== 33'd1 || co_a[5] !== e5o[i]) begin
        failures++;
        $display("FAIL w1_sat step%0d cnt=%0h co=%b expected 1/%b",
                 i, cnt_a[5], co_a[5], e5o[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 10000; n++) begin
      set_in($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, rnd33(),
             $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      // occasionally park near the top so wraps and saturation happen often
      if ($urandom_range(0, 15) == 0) begin
        ld     = 1'b1;
        ld_val = 33'h1_FFFF_FFFF - 33'($urandom_range(0, 2));
      end
      tick();
      for (int g = 0; g < NI; g++) begin
        longint unsigned mx;
        mx = (64'd1 << W_T[g]) - 64'd1;
        checks++;
        if (64'(cnt_a[g]) !== m_cnt[g] || co_a[g] !== m_co[g] || ovf_a[g] !== m_ovf[g]
            || tc_a[g] !== (m_cnt[g] == mx)) begin
          failures++;
          $display("FAIL random cyc%0d inst%0d cnt=%0h co=%b ovf=%b tc=%b expected %0h/%b/%b/%b",
                   n, g, cnt_a[g], co_a[g], ovf_a[g], tc_a[g], m_cnt[g], m_co[g], m_ovf[g],
                   m_cnt[g] == mx);
        end
      end
    end
  endtask

  initial begin
    set_in(1'b1, 1'b0, 33'd0, 1'b0, 1'b0);
    @(negedge clk);
    tick();
    test_reset();
    test_wrap();
    test_sat();
    test_ld_priority();
    test_ovf_clr();
    test_width1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
